// File: rtl/decode_writeback.sv
// decode_writeback: Y86-64 SEQ decode and write-back stage.
// Derives srcA/srcB/dstE/dstM from the fetched instruction and reads
// valA/valB from a 15-entry register file. valE/valM are committed at
// the clock edge. A RUN/HALTED machine freezes the register file once a
// halt or an error retires.
// Optional macro WB_BYPASS_EN forwards same-cycle writes to valA/valB.
module decode_writeback #(
   parameter logic [63:0] RSP_INIT = 64'd1016,
   parameter int unsigned NREG     = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   input  logic        wb_en,
   input  logic        hlt,
   input  logic        imem_error,
   input  logic        instr_valid,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic        halted,
   input  logic [3:0]  dbg_sel,
   output logic [63:0] dbg_val
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RRSP  = 4'h4;

   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [63:0] regs [NREG];
   logic [63:0] valA_reg;
   logic [63:0] valB_reg;
   logic        commit;
   logic        unused_ifun;

   // ifun only travels alongside icode; decode never looks at it
   assign unused_ifun = ^ifun;

   // Register ID decode from icode/rA/rB; invalid icodes fall to "none"
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      unique case (icode)
         I_CMOV: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;
         end
         I_IRMOV: begin
            dstE = rB;
         end
         I_RMMOV: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOV: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = RRSP;
            dstE = RRSP;
         end
         I_RET: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
         end
         I_PUSH: begin
            srcA = rA;
            srcB = RRSP;
            dstE = RRSP;
         end
         I_POP: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
            dstM = rA;
         end
         default: begin
         end
      endcase
   end

   assign commit = wb_en && (state_q == RUN);
   assign halted = (state_q == HALTED);

   // State register; only reset leaves HALTED
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a retiring halt or fetch error freezes the machine
   always_comb begin
      state_d = state_q;
      if (commit && (hlt || imem_error || instr_valid)) begin
         state_d = HALTED;
      end
   end

   // Register file write; the dstM assignment comes last so popq %rsp keeps valM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= (i == 32'(RRSP)) ? RSP_INIT : '0;
         end
      end else if (commit) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (dstE == 4'(i)) begin
               regs[i] <= valE;
            end
            if (dstM == 4'(i)) begin
               regs[i] <= valM;
            end
         end
      end
   end

   // Stored-value reads; ID F never matches an entry and reads as zero
   always_comb begin
      valA_reg = '0;
      valB_reg = '0;
      dbg_val  = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (srcA == 4'(i)) begin
            valA_reg = regs[i];
         end
         if (srcB == 4'(i)) begin
            valB_reg = regs[i];
         end
         if (dbg_sel == 4'(i)) begin
            dbg_val = regs[i];
         end
      end
   end

`ifdef WB_BYPASS_EN
   // Forward a write committing at the next edge; dstM outranks dstE
   always_comb begin
      valA = valA_reg;
      valB = valB_reg;
      if (commit && srcA != RNONE) begin
         if (srcA == dstM) begin
            valA = valM;
         end else if (srcA == dstE) begin
            valA = valE;
         end
      end
      if (commit && srcB != RNONE) begin
         if (srcB == dstM) begin
            valB = valM;
         end else if (srcB == dstE) begin
            valB = valE;
         end
      end
   end
`else
   // Reads see stored contents only
   always_comb begin
      valA = valA_reg;
      valB = valB_reg;
   end
`endif

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 SEQ stage directly downstream of the fetch stage.
- Consumes icode/ifun/rA/rB plus the fetch status flags, and derives srcA/srcB/dstE/dstM.
- Reads valA/valB combinationally from a 15-entry 64-bit register file.
- Commits valE/valM at the clock edge. A RUN/HALTED state machine freezes architectural state once halt or an error retires.

Parameters:
- RSP_INIT, 64'd1016: reset value of %rsp (reg 4), the top 8-byte slot of the 1024-byte memory.
- NREG, 15: number of architectural registers; ID 4'hF means "none".

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- icode  in  4  from fetch
- ifun  in  4  from fetch; carried only, not used for decode
- rA  in  4  from fetch
- rB  in  4  from fetch
- cnd  in  1  condition result from execute; qualifies cmovXX
- valE  in  64  ALU result to write back
- valM  in  64  memory read data to write back
- wb_en  in  1  commit strobe; the current instruction retires at this edge
- hlt  in  1  halt flag from fetch
- imem_error  in  1  fetch address error
- instr_valid  in  1  fetch invalid-instruction flag; 1 = invalid
- srcA, srcB, dstE, dstM  out  4 each  decoded register IDs
- valA, valB  out  64 each  register read data
- halted  out  1  state == HALTED
- dbg_sel  in  4  debug read select
- dbg_val  out  64  reg[dbg_sel]; 0 when dbg_sel == F

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high.
- On reset assertion (immediately, any cycle):
  - regs 0–14 = 0, except reg 4 = RSP_INIT.
  - state = RUN; halted = 0.
  - Any write pending in that cycle is dropped.
- srcA (combinational):
  - rA for icode 2, 4, 6, A.
  - 4 for icode B, 9.
  - Otherwise F.
- srcB (combinational):
  - rB for icode 4, 5, 6.
  - 4 for icode 8, 9, A, B.
  - Otherwise F.
- dstE (combinational):
  - icode 2: rB if cnd, else F.
  - icode 3, 6: rB.
  - icode 8, 9, A, B: 4.
  - Otherwise F.
- dstM (combinational): rA for icode 5, B; otherwise F.
- Invalid icode (>B): all four IDs are F.
- Reads:
  - valA = reg[srcA]; valB = reg[srcB]; 0 when the ID is F.
  - Pure combinational read, zero latency.
  - A read during a same-cycle write returns the OLD value unless the optional bypass is enabled.
- Writes, on the rising clk when wb_en=1 and state==RUN:
  - reg[dstE] <= valE when dstE != F.
  - reg[dstM] <= valM when dstM != F.
  - If dstE == dstM (popq %rsp), the valM write wins.
  - Writes to ID F are ignored; ID F has no storage.
- State machine (2 states):
  - RUN -> HALTED on a wb_en edge when any of hlt, imem_error, instr_valid is set.
  - The retiring halt/error instruction still performs its own writes; all four IDs are F, so it writes nothing.
  - HALTED: all writes ignored, reads remain valid. Exit only via reset.
- wb_en=0: no state change; outputs track the inputs combinationally.
- No internal pipelining: write-back latency is one edge after wb_en is sampled.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - If srcA matches a write that commits at the next edge (wb_en && RUN && ID != F), valA returns the incoming value. srcB/valB behave the same way.
  - dstM match takes precedence over dstE match.
- Undefined: valA/valB reflect stored register contents only.

Test Plan:
- Reset: assert reset mid-cycle with wb_en=1, icode=3, rB=2, valE=16 -> reg2 stays 0; dbg_sel=4 reads 1016; halted=0.
- irmovq: icode=3, rB=2, valE=16, wb_en pulse -> dstE=2; next cycle dbg_sel=2 reads 16.
- opq read: regs rax=0, rbx=12; icode=6, rA=0, rB=3 -> srcA=0, srcB=3, valA=0, valB=12.
- cmovXX:
  - icode=2, rA=2, rB=1, cnd=0, valE=16, wb_en -> dstE=F, rcx unchanged (0).
  - Same with cnd=1 -> rcx=16.
- popq %rsp: icode=B, rA=4, valE=1024, valM=0x55, wb_en -> rsp=0x55.
- Halt freeze: icode=0, hlt=1, wb_en -> halted=1. Then icode=3, rB=1, valE=7, wb_en -> rcx unchanged. After reset, halted=0.
- Bypass, WB_BYPASS_EN defined: icode=6, rA=3, rB=3, valE=5, wb_en=1 in the same cycle -> valA=valB=5 before the edge. Undefined -> valA=valB=old rbx.
